// File: rtl/fifo_sample_unpacker_pkg.sv
// Capture-word layout and read-side FSM encoding shared by the ADC FIFO writer and reader.
package fifo_sample_unpacker_pkg;

    localparam int OR_BIT           = 31;
    localparam int TRIG_BIT         = 30;
    localparam int SAMPLE2_LSB      = 20;
    localparam int SAMPLE1_LSB      = 10;
    localparam int SAMPLE0_LSB      = 0;
    localparam int SAMPLES_PER_WORD = 3;
    localparam int BYTES_PER_WORD   = 4;
    localparam int LAYOUT_SAMPLE_W  = 10;

    localparam logic [2:0] WORD_BYTES  = 3'(BYTES_PER_WORD);
    localparam logic [2:0] LAST_BYTE   = 3'(BYTES_PER_WORD - 1);
    localparam logic [1:0] LAST_SAMPLE = 2'(SAMPLES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_t;

    function automatic logic [LAYOUT_SAMPLE_W-1:0] sample_slice(input logic [31:0] word,
                                                               input logic [1:0]  idx);
        logic [LAYOUT_SAMPLE_W-1:0] s;
        s = '0;
        case (idx)
            2'd0:    s = word[SAMPLE0_LSB +: LAYOUT_SAMPLE_W];
            2'd1:    s = word[SAMPLE1_LSB +: LAYOUT_SAMPLE_W];
            2'd2:    s = word[SAMPLE2_LSB +: LAYOUT_SAMPLE_W];
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fifo_sample_unpacker_byte_assembler.sv
// Issues FIFO reads and shifts bytes MSB-first into a 32-bit capture word.
module fifo_byte_assembler
    import fifo_sample_unpacker_pkg::*;
(
    input  logic        clk_100mhz,
    input  logic        reset_i,
    input  logic        fetch_en,
    input  logic        word_ready,
    output logic        fifo_read_fifoen,
    input  logic        fifo_read_fifoempty,
    input  logic [7:0]  fifo_read_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        word_done
);

    logic [2:0] byte_cnt;
    logic       pending;
    logic [2:0] in_flight;

    always_comb begin
        in_flight        = byte_cnt + {2'b00, pending};
        fifo_read_fifoen = fetch_en && !fifo_read_fifoempty && (in_flight < WORD_BYTES);
        // Last byte lands this cycle; lets the FSM enter EMIT as the word completes.
        word_done        = pending && (byte_cnt == LAST_BYTE);
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset_i) begin
            byte_cnt   <= '0;
            pending    <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            pending <= fifo_read_fifoen;
            if (pending) begin
                word     <= {word[23:0], fifo_read_data};
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == LAST_BYTE)
                    word_valid <= 1'b1;
            end
            if (word_ready) begin
                byte_cnt   <= '0;
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_sample_unpacker.sv
// Reads capture words from the ADC FIFO and streams them as 10-bit samples.
// Optional UNPACK_OR_COUNT_EN adds or_count_o, a saturating count of overrange samples.
module fifo_sample_unpacker
    import fifo_sample_unpacker_pkg::*;
#(
    parameter int SAMPLE_W = 10,
    parameter int CNT_W    = 32
) (
    input  logic                clk_100mhz,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    max_samples_i,
    output logic                fifo_read_fifoen,
    input  logic                fifo_read_fifoempty,
    input  logic [7:0]          fifo_read_data,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_or_o,
    output logic                sample_trig_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                busy_o,
    output logic                done_o,
`ifdef UNPACK_OR_COUNT_EN
    output logic [CNT_W-1:0]    or_count_o,
`endif
    output logic [CNT_W-1:0]    samples_out_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   max_q;
    logic [CNT_W-1:0]   count_next;
    logic [1:0]         idx_q;
    logic [31:0]        word;
    logic               word_valid;
    logic               word_done;
    logic               word_ready;
    logic               handshake;

    fifo_byte_assembler u_assembler (
        .clk_100mhz          (clk_100mhz),
        .reset_i             (reset_i),
        .fetch_en            (state_q == FETCH),
        .word_ready          (word_ready),
        .fifo_read_fifoen    (fifo_read_fifoen),
        .fifo_read_fifoempty (fifo_read_fifoempty),
        .fifo_read_data      (fifo_read_data),
        .word                (word),
        .word_valid          (word_valid),
        .word_done           (word_done)
    );

    always_ff @(posedge clk_100mhz) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        word_ready     = 1'b0;
        sample_valid_o = (state_q == EMIT) && word_valid;
        handshake      = sample_valid_o && sample_ready_i;
        count_next     = samples_out_o + CNT_W'(1);
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == DONE);
        sample_o       = '0;
        sample_or_o    = 1'b0;
        sample_trig_o  = 1'b0;
        if (state_q == EMIT) begin
            sample_o      = sample_slice(word, idx_q);
            sample_or_o   = word[OR_BIT];
            sample_trig_o = word[TRIG_BIT];
        end
        case (state_q)
            IDLE:  if (start_i) state_d = (max_samples_i == '0) ? DONE : FETCH;
            FETCH: if (word_done) state_d = EMIT;
            EMIT: begin
                if (handshake) begin
                    // Reaching the count drops any samples left in the word.
                    if (count_next == max_q) begin
                        state_d    = DONE;
                        word_ready = 1'b1;
                    end else if (idx_q == LAST_SAMPLE) begin
                        state_d    = FETCH;
                        word_ready = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset_i) begin
            max_q         <= '0;
            samples_out_o <= '0;
            idx_q         <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                max_q         <= max_samples_i;
                samples_out_o <= '0;
                idx_q         <= '0;
            end
            if (handshake) begin
                samples_out_o <= count_next;
                idx_q         <= (idx_q == LAST_SAMPLE) ? 2'd0 : idx_q + 2'd1;
            end
        end
    end

`ifdef UNPACK_OR_COUNT_EN
    always_ff @(posedge clk_100mhz) begin
        if (reset_i)
            or_count_o <= '0;
        else if (state_q == IDLE && start_i)
            or_count_o <= '0;
        else if (handshake && sample_or_o && or_count_o != '1)
            or_count_o <= or_count_o + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_sample_unpacker.sv
// Directed bench for fifo_sample_unpacker: byte FIFO model, handshake monitor, vector table.
module tb_fifo_sample_unpacker;

    logic        clk_100mhz = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] max_samples_i = '0;
    logic        fifo_read_fifoen;
    logic        fifo_read_fifoempty;
    logic [7:0]  fifo_read_data = '0;
    logic [9:0]  sample_o;
    logic        sample_or_o;
    logic        sample_trig_o;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
    logic [31:0] samples_out_o;
`ifdef UNPACK_OR_COUNT_EN
    logic [31:0] or_count_o;
`endif

    fifo_sample_unpacker #(.SAMPLE_W(10), .CNT_W(32)) dut (
        .clk_100mhz          (clk_100mhz),
        .reset_i             (reset_i),
        .start_i             (start_i),
        .max_samples_i       (max_samples_i),
        .fifo_read_fifoen    (fifo_read_fifoen),
        .fifo_read_fifoempty (fifo_read_fifoempty),
        .fifo_read_data      (fifo_read_data),
        .sample_o            (sample_o),
        .sample_or_o         (sample_or_o),
        .sample_trig_o       (sample_trig_o),
        .sample_valid_o      (sample_valid_o),
        .sample_ready_i      (sample_ready_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
`ifdef UNPACK_OR_COUNT_EN
        .or_count_o          (or_count_o),
`endif
        .samples_out_o       (samples_out_o)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Byte FIFO model: data appears the cycle after a read enable.
    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    logic       force_empty = 1'b0;
    assign fifo_read_fifoempty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk_100mhz) begin
        if (fifo_read_fifoen && rd_ptr != wr_ptr) begin
            fifo_read_data <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 6'd1;
        end
    end

    // Monitor on the falling edge, away from the DUT's active edge.
    int          rd_cnt = 0, done_cnt = 0, got_n = 0;
    int          viol_empty = 0, viol_state = 0, viol_hold = 0;
    logic [11:0] got_smp [0:63];
    logic [11:0] prev_smp = '0;
    logic        prev_stall = 1'b0;
    logic [11:0] cur;

    always @(negedge clk_100mhz) begin
        cur = {sample_o, sample_or_o, sample_trig_o};
        if (fifo_read_fifoen) rd_cnt++;
        if (fifo_read_fifoen && fifo_read_fifoempty) viol_empty++;
        if (fifo_read_fifoen && (!busy_o || sample_valid_o || done_o)) viol_state++;
        if (done_o) done_cnt++;
        if (prev_stall && !reset_i && (!sample_valid_o || cur != prev_smp)) viol_hold++;
        if (sample_valid_o && sample_ready_i && got_n < 64) begin
            got_smp[got_n] = cur;
            got_n++;
        end
        prev_stall = sample_valid_o && !sample_ready_i && !reset_i;
        prev_smp   = cur;
    end

    int tests = 0, failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #2;
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w[31:24]; wr_ptr = wr_ptr + 6'd1;
        mem[wr_ptr] = w[23:16]; wr_ptr = wr_ptr + 6'd1;
        mem[wr_ptr] = w[15:8];  wr_ptr = wr_ptr + 6'd1;
        mem[wr_ptr] = w[7:0];   wr_ptr = wr_ptr + 6'd1;
    endtask

    function automatic logic [11:0] mk(input logic [9:0] s, input logic o, input logic t);
        return {s, o, t};
    endfunction

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          nwords;
        logic [31:0] max;
        bit          toggle;
        bit          stall;
        int          exp_n;
        logic [71:0] exp;
        int          exp_reads;
        int          exp_or;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        int base_got, base_rd, base_done, cyc, lat, stall_left;
        bit fin, stall_used;

        vecs[0] = '{32'hBFF556AA, 32'h0, 1, 32'd3, 1'b0, 1'b0, 3,
                    {36'h0, mk(10'h3FF,1,0), mk(10'h155,1,0), mk(10'h2AA,1,0)}, 4, 3};
        vecs[1] = '{32'hBFF556AA, 32'h0, 1, 32'd2, 1'b0, 1'b0, 2,
                    {48'h0, mk(10'h155,1,0), mk(10'h2AA,1,0)}, 4, 2};
        vecs[2] = '{32'h0, 32'h0, 0, 32'd0, 1'b0, 1'b0, 0, 72'h0, 0, 0};
        vecs[3] = '{32'hBFF556AA, 32'h5233C00F, 2, 32'd6, 1'b1, 1'b1, 6,
                    {mk(10'h123,0,1), mk(10'h0F0,0,1), mk(10'h00F,0,1),
                     mk(10'h3FF,1,0), mk(10'h155,1,0), mk(10'h2AA,1,0)}, 8, 3};

        tick(); tick(); tick();
        check("reset fifoen", {31'b0, fifo_read_fifoen}, 32'd0);
        check("reset valid", {31'b0, sample_valid_o}, 32'd0);
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset done", {31'b0, done_o}, 32'd0);
        check("reset samples_out", samples_out_o, 32'd0);
        check("reset sample", {20'b0, sample_o, sample_or_o, sample_trig_o}, 32'd0);
        reset_i = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            if (vecs[k].nwords > 0) push_word(vecs[k].w0);
            if (vecs[k].nwords > 1) push_word(vecs[k].w1);
            base_got = got_n; base_rd = rd_cnt; base_done = done_cnt;
            sample_ready_i = 1'b1;
            start_i = 1'b1; max_samples_i = vecs[k].max;
            tick();
            start_i = 1'b0; max_samples_i = 32'd1;
            cyc = 1; lat = -1; fin = 0; stall_used = 0; stall_left = 0;
            while (!fin && cyc < 400) begin
                if (sample_valid_o && lat < 0) lat = cyc;
                if (done_o) fin = 1;
                else begin
                    start_i = (k == 3 && cyc == 10);
                    if (vecs[k].toggle) sample_ready_i = ~sample_ready_i;
                    if (vecs[k].stall && !stall_used && (rd_cnt - base_rd) == 2) begin
                        force_empty = 1'b1; stall_left = 5; stall_used = 1;
                    end else if (stall_left > 0) begin
                        stall_left--;
                        if (stall_left == 0) force_empty = 1'b0;
                    end
                    tick();
                    cyc++;
                end
            end
            start_i = 1'b0; force_empty = 1'b0; sample_ready_i = 1'b1;
            tick(); tick(); tick();
            check($sformatf("v%0d sample count", k), got_n - base_got, vecs[k].exp_n);
            for (int i = 0; i < vecs[k].exp_n; i++)
                check($sformatf("v%0d sample %0d", k, i), {20'b0, got_smp[base_got + i]},
                      {20'b0, vecs[k].exp[i*12 +: 12]});
            check($sformatf("v%0d done pulses", k), done_cnt - base_done, 1);
            check($sformatf("v%0d read enables", k), rd_cnt - base_rd, vecs[k].exp_reads);
            check($sformatf("v%0d samples_out", k), samples_out_o, vecs[k].exp_n);
            check($sformatf("v%0d busy after", k), {31'b0, busy_o}, 32'd0);
            if (k == 0) check("v0 latency >= 6", (lat >= 6) ? 32'd1 : 32'd0, 32'd1);
`ifdef UNPACK_OR_COUNT_EN
            check($sformatf("v%0d or_count", k), or_count_o, vecs[k].exp_or);
`endif
        end

        // max = 0: DONE on the cycle after start, then back to IDLE.
        start_i = 1'b1; max_samples_i = 32'd0;
        tick();
        start_i = 1'b0;
        check("max0 done pulse", {31'b0, done_o}, 32'd1);
        tick();
        check("max0 done clears", {31'b0, done_o}, 32'd0);
        check("max0 idle", {31'b0, busy_o}, 32'd0);

        // Reset during EMIT at sample index 1, then a normal run.
        push_word(32'hBFF556AA);
        sample_ready_i = 1'b0;
        start_i = 1'b1; max_samples_i = 32'd3;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (!sample_valid_o && cyc < 50) begin tick(); cyc++; end
        check("rst first valid seen", {31'b0, sample_valid_o}, 32'd1);
        sample_ready_i = 1'b1;
        tick();
        sample_ready_i = 1'b0;
        check("rst idx1 sample", {22'b0, sample_o}, 32'h155);
        reset_i = 1'b1;
        tick();
        check("rst valid", {31'b0, sample_valid_o}, 32'd0);
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst samples_out", samples_out_o, 32'd0);
        check("rst sample", {20'b0, sample_o, sample_or_o, sample_trig_o}, 32'd0);
        check("rst fifoen", {31'b0, fifo_read_fifoen}, 32'd0);
        reset_i = 1'b0; sample_ready_i = 1'b1;
        tick();
        push_word(32'hBFF556AA);
        base_got = got_n; base_done = done_cnt;
        start_i = 1'b1; max_samples_i = 32'd1;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 50) begin tick(); cyc++; end
        tick();
        check("post-rst done", done_cnt - base_done, 1);
        check("post-rst count", got_n - base_got, 1);
        check("post-rst sample", {20'b0, got_smp[base_got]}, {20'b0, mk(10'h2AA,1,0)});
        check("post-rst samples_out", samples_out_o, 32'd1);

        check("no read while empty", viol_empty, 0);
        check("no read outside FETCH", viol_state, 0);
        check("held while stalled", viol_hold, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
